if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage that sits between the instruction memory and decode. It owns the fetch PC and issues one read per cycle to a synchronous instruction memory, buffering returned instructions in a DEPTH-entry queue. Decode takes instructions through a valid/ready handshake. Redirects (call, branch, return) retarget the PC with fixed priority, flush the queue and discard in-flight data.

---
 rtl/if_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// ============================================================================
// Module   : if_fetch_queue
// Brief    : Instruction-fetch stage: owns the PC, issues one synchronous
//            memory read per cycle and buffers returned instructions in a
//            DEPTH-entry queue towards decode. Optional bubble counter is
//            enabled by defining IF_FETCH_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               call_vld,
    input  logic [ADDR_W-1:0]  call_pc,
    input  logic               br_vld,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic               ret_vld,
    input  logic [ADDR_W-1:0]  ret_pc,
    output logic               im_rd_en,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_instr,
    output logic               out_vld,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_inc,
    input  logic               out_rdy
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_bubble_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               inflight_q, inflight_d;
    logic               kill_q, kill_d;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  inc_mem   [DEPTH];

    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic [CNT_W:0]     occupancy;
    logic               issue;
    logic               enq;
    logic               deq;

    always_comb begin
        redirect  = call_vld | br_vld | ret_vld;
        target    = call_vld ? call_pc : (br_vld ? br_pc : ret_pc);
        // Reserve a slot for the outstanding read so a response always fits.
        occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        issue     = ~rst & ~redirect & (occupancy < (CNT_W + 1)'(DEPTH));
        enq       = inflight_q & ~kill_q & ~redirect;
        deq       = out_vld & out_rdy;
    end

    always_comb begin
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = issue;
        kill_d     = redirect & inflight_q;
        if (redirect) begin
            pc_d     = target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) pc_d     = pc_q + 1'b1;
            if (enq)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq)   rd_ptr_d = rd_ptr_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    // In the response cycle pc_q already equals the issuing address + 1.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr_q] <= im_instr;
            inc_mem[wr_ptr_q]   <= pc_q;
        end
    end

    assign im_rd_en   = issue;
    assign im_addr    = pc_q;
    assign out_vld    = (count_q != '0);
    assign out_instr  = instr_mem[rd_ptr_q];
    assign out_pc_inc = inc_mem[rd_ptr_q];

`ifdef IF_FETCH_PERF_EN
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (out_rdy & ~out_vld & ~(&bubble_cnt_q)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Self-checking bench for if_fetch_queue: directed scenarios plus
//            randomized redirect/backpressure against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        call_vld = 1'b0, br_vld = 1'b0, ret_vld = 1'b0;
    logic [15:0] call_pc = '0, br_pc = '0, ret_pc = '0;
    logic        im_rd_en;
    logic [15:0] im_addr;
    logic [15:0] im_instr = '0;
    logic        out_vld;
    logic [15:0] out_instr;
    logic [15:0] out_pc_inc;
    logic        out_rdy = 1'b0;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
`endif

    if_fetch_queue #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .call_vld   (call_vld),
        .call_pc    (call_pc),
        .br_vld     (br_vld),
        .br_pc      (br_pc),
        .ret_vld    (ret_vld),
        .ret_pc     (ret_pc),
        .im_rd_en   (im_rd_en),
        .im_addr    (im_addr),
        .im_instr   (im_instr),
        .out_vld    (out_vld),
        .out_instr  (out_instr),
        .out_pc_inc (out_pc_inc),
        .out_rdy    (out_rdy)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data = address ^ 0xA5A5, one cycle late.
    always @(posedge clk) begin
        if (im_rd_en) im_instr <= im_addr ^ 16'hA5A5;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        else             n_pass++;
    endtask

    // Reference model: fetch PC, ordered list of buffered instructions,
    // and the address of the single outstanding read (if any).
    logic [15:0] m_pc;
    logic [15:0] mq_instr[$];
    logic [15:0] mq_inc[$];
    bit          m_infl;
    logic [15:0] m_infl_addr;
    logic [31:0] m_bub;

    task automatic model_reset();
        m_pc   = RESET_PC;
        mq_instr.delete();
        mq_inc.delete();
        m_infl = 1'b0;
        m_bub  = '0;
    endtask

    // One cycle: drive at negedge, check, advance model, return at next negedge.
    task automatic step(input bit c, input bit b, input bit r,
                        input logic [15:0] cp, input logic [15:0] bp, input logic [15:0] rp,
                        input bit rdy);
        bit          redir, e_rd, e_vld;
        logic [15:0] tgt, nxt;
        call_vld = c; br_vld = b; ret_vld = r;
        call_pc = cp; br_pc = bp; ret_pc = rp;
        out_rdy = rdy;
        #1;
        redir = c | b | r;
        tgt   = c ? cp : (b ? bp : rp);
        e_rd  = !redir && ((mq_instr.size() + (m_infl ? 1 : 0)) < DEPTH);
        e_vld = mq_instr.size() != 0;
        check_eq("im_rd_en", {31'd0, im_rd_en}, {31'd0, e_rd});
        check_eq("im_addr",  {16'd0, im_addr},  {16'd0, m_pc});
        check_eq("out_vld",  {31'd0, out_vld},  {31'd0, e_vld});
        if (e_vld) begin
            check_eq("out_instr",  {16'd0, out_instr},  {16'd0, mq_instr[0]});
            check_eq("out_pc_inc", {16'd0, out_pc_inc}, {16'd0, mq_inc[0]});
        end
`ifdef IF_FETCH_PERF_EN
        check_eq("perf_bubble_cnt", perf_bubble_cnt, m_bub);
`endif
        if (rdy && !e_vld && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
        if (e_vld && rdy) begin
            void'(mq_instr.pop_front());
            void'(mq_inc.pop_front());
        end
        if (redir) begin
            mq_instr.delete();
            mq_inc.delete();
            m_pc   = tgt;
            m_infl = 1'b0;
        end else begin
            if (m_infl) begin
                nxt = m_infl_addr + 16'd1;
                mq_instr.push_back(m_infl_addr ^ 16'hA5A5);
                mq_inc.push_back(nxt);
            end
            if (e_rd) begin
                m_infl      = 1'b1;
                m_infl_addr = m_pc;
                m_pc        = m_pc + 16'd1;
            end else begin
                m_infl = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, rdy);
    endtask

    task automatic mid_reset();
        call_vld = 1'b0; br_vld = 1'b0; ret_vld = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_out_vld",  {31'd0, out_vld},  32'd0);
        check_eq("rst_im_rd_en", {31'd0, im_rd_en}, 32'd0);
        check_eq("rst_im_addr",  {16'd0, im_addr},  {16'd0, RESET_PC});
`ifdef IF_FETCH_PERF_EN
        check_eq("rst_perf", perf_bubble_cnt, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("init_out_vld",  {31'd0, out_vld},  32'd0);
        check_eq("init_im_rd_en", {31'd0, im_rd_en}, 32'd0);
        check_eq("init_im_addr",  {16'd0, im_addr},  {16'd0, RESET_PC});
        @(negedge clk);
        rst = 1'b0;

        // First instruction lands two edges after release.
        idle(1'b1);
        check_eq("first_vld_early", {31'd0, out_vld}, 32'd0);
        idle(1'b1);
        check_eq("first_vld",   {31'd0, out_vld},    32'd1);
        check_eq("first_instr", {16'd0, out_instr},  32'h0000_A5B5);
        check_eq("first_inc",   {16'd0, out_pc_inc}, 32'h0000_0011);
        repeat (6) idle(1'b1);

        // Backpressure fills the queue, then drains in order.
        repeat (10) idle(1'b0);
        check_eq("full_no_issue", {31'd0, im_rd_en}, 32'd0);
        repeat (8) idle(1'b1);

        // Branch with three queued entries and a read outstanding.
        repeat (2) idle(1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0200, 16'h0, 1'b0);
        check_eq("br_flush", {31'd0, out_vld}, 32'd0);
        idle(1'b1);
        idle(1'b1);
        check_eq("br_vld",   {31'd0, out_vld},    32'd1);
        check_eq("br_instr", {16'd0, out_instr},  32'h0000_A7A5);
        check_eq("br_inc",   {16'd0, out_pc_inc}, 32'h0000_0201);

        // All three redirects at once: call wins.
        step(1'b1, 1'b1, 1'b1, 16'h0100, 16'h0200, 16'h0300, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check_eq("prio_inc", {16'd0, out_pc_inc}, 32'h0000_0101);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'hFFFF, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check_eq("wrap_inc",  {16'd0, out_pc_inc}, 32'h0000_0000);
        check_eq("wrap_addr", {16'd0, im_addr},    32'h0000_0001);
        repeat (3) idle(1'b1);

        // Reset mid-stream with two entries queued.
        idle(1'b0);
        mid_reset();
        idle(1'b1);
        idle(1'b1);
        check_eq("post_rst_vld", {31'd0, out_vld}, 32'd1);
`ifdef IF_FETCH_PERF_EN
        check_eq("post_rst_bubbles", perf_bubble_cnt, 32'd2);
`endif

        // Randomized redirects and backpressure.
        for (int i = 0; i < 400; i++) begin
            int          sel;
            logic [15:0] cp, bp, rp;
            sel = $urandom_range(0, 19);
            cp  = 16'($urandom);
            bp  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            rp  = 16'($urandom);
            step(sel == 0, (sel == 1) || (sel == 3), (sel == 2) || (sel == 3),
                 cp, bp, rp, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
